// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default sizes and
// the sweep FSM state encoding.
package regfile_mp_pkg;

    // Default geometry of the MIPS register file.
    localparam int ADDR_SIZE_DEF = 5;
    localparam int WORD_SIZE_DEF = 32;
    localparam int RD_PORTS_DEF  = 2;

    // Feature switches: hardwired r0 and write-to-read forwarding.
    localparam int ZERO_REG_DEF  = 1;
    localparam int BYPASS_DEF    = 1;

    // CLEAR: storage is being swept to zero, the file is not usable.
    // READY: normal read/write operation.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a load is issued
// (pend_set in decode) and cleared when writeback writes the register.
// The lookup outputs are the raw bits; the top masks them for forwarding.
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int RD_PORTS  = RD_PORTS_DEF,
    parameter int ZERO_REG  = ZERO_REG_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          set_en,
    input  logic [ADDR_SIZE-1:0]          set_addr,
    input  logic                          clr_en,
    input  logic [ADDR_SIZE-1:0]          clr_addr,
    input  logic [RD_PORTS*ADDR_SIZE-1:0] rd_addr,
    output logic [RD_PORTS-1:0]           lookup
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             set_allowed;

    // r0 never has a producer to wait for when it is hardwired.
    assign set_allowed = set_en && !((ZERO_REG != 0) && (set_addr == '0));

    // Next pend vector: clear first so a same-address set in the same
    // cycle wins; a flush overrides everything.
    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[clr_addr] = 1'b0;
        end
        if (set_allowed) begin
            pend_d[set_addr] = 1'b1;
        end
        if (flush) begin
            pend_d = '0;
        end
    end

    // Pend vector register, emptied by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Per-port lookup of the stored pend bit.
    for (genvar i = 0; i < RD_PORTS; i++) begin : g_lookup
        assign lookup[i] = pend_q[rd_addr[i*ADDR_SIZE +: ADDR_SIZE]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file for the MIPS core. Combinational read ports,
// one synchronous write port, write-to-read bypass, hardwired r0, a
// pending-write scoreboard for load-use interlock, and a sweep FSM that
// zeroes storage after reset or a soft clear.
//
// Handshake: there is no per-transfer valid/ready. busy is the inverse of
// "ready": while busy=1 every request (wr_en, pend_set, clr) is dropped and
// all read outputs are 0; while busy=0 every request is accepted in the
// cycle it is presented, with no backpressure.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int RD_PORTS  = RD_PORTS_DEF,
    parameter int ZERO_REG  = ZERO_REG_DEF,
    parameter int BYPASS    = BYPASS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    output logic                          busy,
    input  logic [RD_PORTS*ADDR_SIZE-1:0] rd_addr,
    output logic [RD_PORTS*WORD_SIZE-1:0] rd_data,
    output logic [RD_PORTS-1:0]           rd_pend,
    input  logic                          wr_en,
    input  logic [ADDR_SIZE-1:0]          wr_addr,
    input  logic [WORD_SIZE-1:0]          wr_data,
    input  logic                          pend_set,
    input  logic [ADDR_SIZE-1:0]          pend_addr
);

    localparam int                   DEPTH     = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = {ADDR_SIZE{1'b1}};

    // Sweep FSM state and pointer.
    state_t               state_q;
    state_t               state_d;
    logic [ADDR_SIZE-1:0] ptr_q;
    logic [ADDR_SIZE-1:0] ptr_d;

    // Decoded FSM controls.
    logic ready;
    logic sweep_we;
    logic flush;

    // Qualified requests seen by storage and scoreboard.
    logic wr_accept;
    logic wr_commit;
    logic pend_accept;

    logic [WORD_SIZE-1:0] regs [DEPTH];
    logic [RD_PORTS-1:0]  sb_lookup;

    // State register: reset (and any reset mid-sweep) restarts the sweep at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state and controls: CLEAR walks every address once, READY waits
    // for a soft clear request.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ready    = 1'b0;
        sweep_we = 1'b0;
        flush    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                sweep_we = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end
            end
            ST_READY: begin
                ready = 1'b1;
                if (clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    flush   = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy = ~ready;

    // A clear request in READY wins over a write presented in the same cycle.
    assign wr_accept   = ready && wr_en && !clr;
    assign pend_accept = ready && pend_set && !clr;
    // Writes to a hardwired r0 never reach storage.
    assign wr_commit   = wr_accept && !((ZERO_REG != 0) && (wr_addr == '0));

    // Storage: the sweep owns the write port in CLEAR, writeback in READY.
    // Deliberately no reset; the sweep is the only initialisation.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            regs[ptr_q] <= '0;
        end else if (wr_commit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    regfile_mp_scoreboard #(
        .ADDR_SIZE (ADDR_SIZE),
        .RD_PORTS  (RD_PORTS),
        .ZERO_REG  (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .set_en   (pend_accept),
        .set_addr (pend_addr),
        .clr_en   (wr_accept),
        .clr_addr (wr_addr),
        .rd_addr  (rd_addr),
        .lookup   (sb_lookup)
    );

    // Read ports: r0 forcing has top priority, then same-cycle forwarding,
    // then storage. Everything reads as 0 while the sweep runs.
    for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
        logic [ADDR_SIZE-1:0] addr;
        logic                 zero_hit;
        logic                 fwd;

        assign addr     = rd_addr[i*ADDR_SIZE +: ADDR_SIZE];
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);
        assign fwd      = (BYPASS != 0) && ready && wr_en && (wr_addr == addr);

        assign rd_data[i*WORD_SIZE +: WORD_SIZE] =
            (!ready || zero_hit) ? '0      :
            fwd                  ? wr_data :
                                   regs[addr];

        // A forwarded value is already the producer's result, so no stall.
        assign rd_pend[i] = ready && !fwd && sb_lookup[i];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp. Two instances share every input: one
// with forwarding, one without. A driver issues one input vector per cycle
// and pushes the expected outputs of both instances, taken from a
// behavioural model, into a queue; a monitor pops and compares every cycle.
module tb_regfile_mp;

    localparam int AW    = 5;
    localparam int WW    = 32;
    localparam int NREG  = 32;
    localparam int EXP_W = 1 + 64 + 2 + 64 + 2;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic [9:0]  rd_addr;

    logic        busy;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic        nb_busy;
    logic [63:0] nb_rd_data;
    logic [1:0]  nb_rd_pend;

    // Behavioural model: contents, pending flags, remaining sweep cycles.
    logic [31:0] mem [NREG];
    logic [31:0] pend_m;
    int          clear_left;

    logic [EXP_W-1:0] exp_q [$];
    int checks;
    int errors;
    int cycle;

    regfile_mp #(
        .ADDR_SIZE (AW), .WORD_SIZE (WW), .RD_PORTS (2), .ZERO_REG (1), .BYPASS (1)
    ) u_dut (
        .clk (clk), .rst (rst), .clr (clr), .busy (busy),
        .rd_addr (rd_addr), .rd_data (rd_data), .rd_pend (rd_pend),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .pend_set (pend_set), .pend_addr (pend_addr)
    );

    regfile_mp #(
        .ADDR_SIZE (AW), .WORD_SIZE (WW), .RD_PORTS (2), .ZERO_REG (1), .BYPASS (0)
    ) u_nb (
        .clk (clk), .rst (rst), .clr (clr), .busy (nb_busy),
        .rd_addr (rd_addr), .rd_data (nb_rd_data), .rd_pend (nb_rd_pend),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .pend_set (pend_set), .pend_addr (pend_addr)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) mem[r] = '0;
        pend_m     = '0;
        clear_left = NREG;
    endtask

    // Expected read of one port, straight from the read rules.
    task automatic exp_port(input logic [4:0] a, input logic byp, input logic bsy,
                            input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            output logic [31:0] d, output logic p);
        if (bsy || a == 5'd0) begin
            d = '0;
            p = 1'b0;
        end else if (byp && we && wa == a) begin
            d = wd;
            p = 1'b0;
        end else begin
            d = mem[a];
            p = pend_m[a];
        end
    endtask

    // Driver: present one cycle of inputs, queue the expectation, advance model.
    task automatic step(input logic s_rst, input logic s_clr, input logic s_we,
                        input logic [4:0] s_wa, input logic [31:0] s_wd,
                        input logic s_ps, input logic [4:0] s_pa,
                        input logic [4:0] s_r0, input logic [4:0] s_r1);
        logic        bsy;
        logic [31:0] d0, d1, n0, n1;
        logic        p0, p1, q0, q1;
        @(negedge clk);
        rst       = s_rst;
        clr       = s_clr;
        wr_en     = s_we;
        wr_addr   = s_wa;
        wr_data   = s_wd;
        pend_set  = s_ps;
        pend_addr = s_pa;
        rd_addr   = {s_r1, s_r0};
        bsy = s_rst || (clear_left > 0);
        exp_port(s_r0, 1'b1, bsy, s_we, s_wa, s_wd, d0, p0);
        exp_port(s_r1, 1'b1, bsy, s_we, s_wa, s_wd, d1, p1);
        exp_port(s_r0, 1'b0, bsy, s_we, s_wa, s_wd, n0, q0);
        exp_port(s_r1, 1'b0, bsy, s_we, s_wa, s_wd, n1, q1);
        exp_q.push_back({bsy, d1, d0, p1, p0, n1, n0, q1, q0});
        if (s_rst) begin
            model_clear();
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (s_clr) begin
            model_clear();
        end else begin
            if (s_we) begin
                mem[s_wa]    = s_wd;
                pend_m[s_wa] = 1'b0;
            end
            if (s_ps && s_pa != 5'd0) pend_m[s_pa] = 1'b1;
        end
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        step(1'b0, 1'b0, 1'b0, 5'd0, $urandom, 1'b0, 5'd0, r0, r1);
    endtask

    // Fully random inputs; used while a sweep is running (all ignored).
    task automatic junk();
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)));
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare against the queue head.
    initial begin
        logic [EXP_W-1:0] e;
        cycle = 0;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cycle++;
                chk("busy",       64'(busy),       64'(e[132]));
                chk("rd_data",    rd_data,         e[131:68]);
                chk("rd_pend",    64'(rd_pend),    64'(e[67:66]));
                chk("nb_busy",    64'(nb_busy),    64'(e[132]));
                chk("nb_rd_data", nb_rd_data,      e[65:2]);
                chk("nb_rd_pend", 64'(nb_rd_pend), 64'(e[1:0]));
            end
        end
    end

    // Stimulus sequence.
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        pend_set  = 1'b0;
        pend_addr = '0;
        rd_addr   = '0;
        model_clear();

        // Reset, then the 32-cycle sweep with ignored requests
        // (including a write of 0xDEAD to r3).
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd2);
        step(1'b1, 1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 5'd3, 5'd4);
        for (int c = 0; c < NREG; c++) begin
            if (c == 5) step(1'b0, 1'b1, 1'b1, 5'd3, 32'hDEAD, 1'b1, 5'd3, 5'd3, 5'd3);
            else        junk();
        end
        for (int k = 0; k < NREG / 2; k++) idle(5'(2 * k), 5'(2 * k + 1));

        // Write then read on both ports.
        step(1'b0, 1'b0, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd1, 5'd2);
        idle(5'd5, 5'd5);

        // Same-cycle forwarding on port 1.
        step(1'b0, 1'b0, 1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 5'd5, 5'd7);
        idle(5'd7, 5'd7);

        // Hardwired r0: write, read, pend_set are all invisible.
        step(1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Scoreboard set, set-wins-over-clear, then clear.
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
        idle(5'd9, 5'd9);
        step(1'b0, 1'b0, 1'b1, 5'd9, 32'hA5A5_0009, 1'b1, 5'd9, 5'd9, 5'd9);
        idle(5'd9, 5'd9);
        step(1'b0, 1'b0, 1'b1, 5'd9, 32'h5A5A_0009, 1'b0, 5'd0, 5'd9, 5'd9);
        idle(5'd9, 5'd9);

        // Soft clear after writing r4 and marking r12 pending.
        step(1'b0, 1'b0, 1'b1, 5'd4, 32'h55, 1'b1, 5'd12, 5'd4, 5'd12);
        idle(5'd4, 5'd12);
        step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd12);
        for (int c = 0; c < NREG; c++) junk();
        idle(5'd4, 5'd12);

        // Reset at sweep cycle 10 restarts the full sweep.
        step(1'b0, 1'b0, 1'b1, 5'd6, 32'h77, 1'b0, 5'd0, 5'd6, 5'd6);
        step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd6);
        for (int c = 0; c < 10; c++) junk();
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd6);
        for (int c = 0; c < NREG; c++) junk();
        idle(5'd6, 5'd6);

        // Random traffic on a narrow address range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            step(1'b0, 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)));
        end

        @(negedge clk);
        #4;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
